// File: rtl/principal_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : principal_scan_sequencer
// Brief    : Walks the lattice grid in principal order (left-to-right, then
//            top-to-bottom) once per start request. It issues one (hor, vert)
//            coordinate per unstalled cycle to the address mapper. Each issue
//            is also delayed by the fixed BRAM read latency, so collision
//            logic sees coordinates aligned with the returned data.
// Revision : 1.0 - initial release
// ============================================================================
module principal_scan_sequencer #(
  parameter  int HPIXELS    = 205,
  parameter  int VPIXELS    = 154,
  parameter  int RW_LATENCY = 3,
  localparam int HOR_SIZE   = $clog2(HPIXELS),
  localparam int VERT_SIZE  = $clog2(VPIXELS)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 stall_in,
  output logic [HOR_SIZE-1:0]  hor_out,
  output logic [VERT_SIZE-1:0] vert_out,
  output logic                 valid_out,
  output logic [HOR_SIZE-1:0]  rd_hor_out,
  output logic [VERT_SIZE-1:0] rd_vert_out,
  output logic                 rd_valid_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 frame_parity_out
);

  // Last column/row, sized to the counters so the compares never depend on
  // the grid size being a power of two.
  localparam logic [HOR_SIZE-1:0]  c_HOR_LAST  = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] c_VERT_LAST = VERT_SIZE'(VPIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  // Next coordinate to issue.
  logic [HOR_SIZE-1:0]    r_hor;
  logic [VERT_SIZE-1:0]   r_vert;
  // Most recently issued coordinate. The issue port shows it while stalled.
  logic [HOR_SIZE-1:0]    r_hor_last;
  logic [VERT_SIZE-1:0]   r_vert_last;
  logic                   r_parity;

  logic                   w_issue;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_load;
  logic                   w_at_last;
  logic                   w_rd_last;
  logic [HOR_SIZE-1:0]    w_hor_issue;
  logic [VERT_SIZE-1:0]   w_vert_issue;

  // Read-latency pipeline. Index 0 is the youngest stage.
  logic                   r_pipe_valid [RW_LATENCY];
  logic [HOR_SIZE-1:0]    r_pipe_hor   [RW_LATENCY];
  logic [VERT_SIZE-1:0]   r_pipe_vert  [RW_LATENCY];

  // Counter is sitting on the final cell of the frame.
  assign w_at_last = (r_hor == c_HOR_LAST) && (r_vert == c_VERT_LAST);

  // The final cell's read data is being delivered this cycle. Only one
  // issue per frame carries this coordinate, so it marks the end of drain.
  assign w_rd_last = r_pipe_valid[RW_LATENCY-1]
                  && (r_pipe_hor[RW_LATENCY-1]  == c_HOR_LAST)
                  && (r_pipe_vert[RW_LATENCY-1] == c_VERT_LAST);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_in) begin
          w_load       = 1'b1;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        w_issue = !stall_in;
        if (!stall_in && w_at_last) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Raster counters: advance along the row, wrap to the next row at the end.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hor  <= '0;
      r_vert <= '0;
    end else if (w_load) begin
      r_hor  <= '0;
      r_vert <= '0;
    end else if (w_issue) begin
      if (r_hor == c_HOR_LAST) begin
        r_hor  <= '0;
        r_vert <= (r_vert == c_VERT_LAST) ? '0 : r_vert + VERT_SIZE'(1);
      end else begin
        r_hor  <= r_hor + HOR_SIZE'(1);
      end
    end
  end

  // Remember the last issued coordinate so the port holds it across stalls.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hor_last  <= '0;
      r_vert_last <= '0;
    end else if (w_issue) begin
      r_hor_last  <= r_hor;
      r_vert_last <= r_vert;
    end
  end

  // Ping-pong buffer select flips once per completed frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_parity <= 1'b0;
    end else if (w_done) begin
      r_parity <= ~r_parity;
    end
  end

  assign w_hor_issue  = w_issue ? r_hor  : r_hor_last;
  assign w_vert_issue = w_issue ? r_vert : r_vert_last;

  // Fixed-latency delay line. It shifts every cycle, stalled or not, because
  // the BRAM returns data a constant number of cycles after each address.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RW_LATENCY; i++) begin
        r_pipe_valid[i] <= 1'b0;
        r_pipe_hor[i]   <= '0;
        r_pipe_vert[i]  <= '0;
      end
    end else begin
      r_pipe_valid[0] <= w_issue;
      r_pipe_hor[0]   <= w_hor_issue;
      r_pipe_vert[0]  <= w_vert_issue;
      for (int i = 1; i < RW_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_hor[i]   <= r_pipe_hor[i-1];
        r_pipe_vert[i]  <= r_pipe_vert[i-1];
      end
    end
  end

  assign hor_out          = w_hor_issue;
  assign vert_out         = w_vert_issue;
  assign valid_out        = w_issue;
  assign rd_hor_out       = r_pipe_hor[RW_LATENCY-1];
  assign rd_vert_out      = r_pipe_vert[RW_LATENCY-1];
  assign rd_valid_out     = r_pipe_valid[RW_LATENCY-1];
  assign busy_out         = w_busy;
  assign done_out         = w_done;
  assign frame_parity_out = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_principal_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_principal_scan_sequencer
// Brief    : Directed and randomized bench for principal_scan_sequencer. The
//            expected outputs come from a cycle-level behavioural model:
//            coordinate k maps to (k mod H, k div H), and read data equals
//            the issue port from LAT cycles earlier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_principal_scan_sequencer;

  localparam int SH   = 4;
  localparam int SV   = 3;
  localparam int LAT  = 3;
  localparam int BH   = 205;
  localparam int BV   = 154;
  localparam int SHW  = $clog2(SH);
  localparam int SVW  = $clog2(SV);
  localparam int BHW  = $clog2(BH);
  localparam int BVW  = $clog2(BV);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-grid DUT signals
  logic           s_rst_n = 1'b0, s_start = 1'b0, s_stall = 1'b0;
  logic [SHW-1:0] s_hor, s_rdh;
  logic [SVW-1:0] s_vert, s_rdvt;
  logic           s_valid, s_rdv, s_busy, s_done, s_par;

  // Default-grid DUT signals
  logic           b_rst_n = 1'b0, b_start = 1'b0, b_stall = 1'b0;
  logic [BHW-1:0] b_hor, b_rdh;
  logic [BVW-1:0] b_vert, b_rdvt;
  logic           b_valid, b_rdv, b_busy, b_done, b_par;

  principal_scan_sequencer #(.HPIXELS(SH), .VPIXELS(SV), .RW_LATENCY(LAT)) u_small (
    .clk_in(clk), .rst_n_in(s_rst_n), .start_in(s_start), .stall_in(s_stall),
    .hor_out(s_hor), .vert_out(s_vert), .valid_out(s_valid),
    .rd_hor_out(s_rdh), .rd_vert_out(s_rdvt), .rd_valid_out(s_rdv),
    .busy_out(s_busy), .done_out(s_done), .frame_parity_out(s_par)
  );

  principal_scan_sequencer u_big (
    .clk_in(clk), .rst_n_in(b_rst_n), .start_in(b_start), .stall_in(b_stall),
    .hor_out(b_hor), .vert_out(b_vert), .valid_out(b_valid),
    .rd_hor_out(b_rdh), .rd_vert_out(b_rdvt), .rd_valid_out(b_rdv),
    .busy_out(b_busy), .done_out(b_done), .frame_parity_out(b_par)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // ---------------- behavioural reference model ----------------
  typedef struct { bit v; int h; int vt; } ent_t;
  ent_t hist[$];
  int   m_h = SH, m_n = SH*SV;
  bit   m_in_scan = 0, m_busy = 0, m_par = 0;
  int   m_k = 0, m_done_at = -1, m_hh = 0, m_hv = 0;

  function automatic logic [63:0] pack(input logic b, input logic d, input logic p,
                                       input logic v, input logic [11:0] h,
                                       input logic [11:0] vt, input logic rv,
                                       input logic [11:0] rh, input logic [11:0] rvt);
    return {11'd0, b, d, p, v, h, vt, rv, rh, rvt};
  endfunction

  task automatic model_reset();
    m_in_scan = 0; m_busy = 0; m_par = 0; m_k = 0; m_done_at = -1;
    m_hh = 0; m_hv = 0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back('{0, 0, 0});
  endtask

  task automatic model_step(input bit rstl, input bit st, input bit sl,
                            output logic [63:0] e);
    ent_t cur, old;
    bit   e_busy, e_done, e_par;
    if (rstl) begin
      model_reset();
      e = '0;
    end else begin
      e_busy = m_busy;
      e_done = (cyc == m_done_at);
      e_par  = m_par;
      cur.v  = m_in_scan && !sl;
      if (cur.v) begin
        m_hh = m_k % m_h;
        m_hv = m_k / m_h;
        m_k++;
        if (m_k == m_n) begin
          m_in_scan = 0;
          m_done_at = cyc + LAT + 1;
        end
      end
      cur.h  = m_hh;
      cur.vt = m_hv;
      old    = hist[0];
      e = pack(e_busy, e_done, e_par, cur.v, 12'(cur.h), 12'(cur.vt),
               old.v, 12'(old.h), 12'(old.vt));
      hist.push_back(cur);
      void'(hist.pop_front());
      if (e_done) begin
        m_busy = 0; m_par = !m_par; m_done_at = -1;
      end else if (!m_busy && st) begin
        m_busy = 1; m_in_scan = 1; m_k = 0;
      end
    end
  endtask

  // ---------------- comparison helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_s(input bit rstl, input bit st, input bit sl, input string tag);
    logic [63:0] e;
    @(posedge clk); #1;
    s_rst_n = !rstl; s_start = st; s_stall = sl;
    model_step(rstl, st, sl, e);
    @(negedge clk);
    chk(tag, pack(s_busy, s_done, s_par, s_valid, 12'(s_hor), 12'(s_vert),
                  s_rdv, 12'(s_rdh), 12'(s_rdvt)), e);
    cyc++;
  endtask

  task automatic step_b(input bit st, input string tag);
    logic [63:0] e;
    @(posedge clk); #1;
    b_start = st; b_stall = 1'b0;
    model_step(1'b0, st, 1'b0, e);
    @(negedge clk);
    chk(tag, pack(b_busy, b_done, b_par, b_valid, 12'(b_hor), 12'(b_vert),
                  b_rdv, 12'(b_rdh), 12'(b_rdvt)), e);
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  done_at, dones, issues, last_h, last_v;
    bit  prev_done;

    // Reset both DUTs, check the reset state.
    step_s(1, 0, 0, "reset");
    step_s(1, 0, 0, "reset");
    @(posedge clk); #1; b_rst_n = 1'b1;
    @(negedge clk);
    chk_int("reset_big_busy", int'(b_busy), 0);
    chk_int("reset_big_parity", int'(b_par), 0);

    // Unstalled frame: done exactly at cycle 16, parity 0->1.
    done_at = -1; dones = 0;
    for (int c = 0; c < 20; c++) begin
      step_s(0, c == 0, 0, "basic");
      if (s_done) begin done_at = c; dones++; end
    end
    chk_int("basic_done_cycle", done_at, 16);
    chk_int("basic_done_count", dones, 1);
    chk_int("basic_parity", int'(s_par), 1);

    // Stall at cycles 3 and 4: done at 18.
    done_at = -1;
    for (int c = 0; c < 22; c++) begin
      step_s(0, c == 0, c == 3 || c == 4, "stall");
      if (s_done) done_at = c;
    end
    chk_int("stall_done_cycle", done_at, 18);

    // Start pulses mid-scan are ignored.
    done_at = -1; dones = 0;
    for (int c = 0; c < 20; c++) begin
      step_s(0, c == 0 || c == 5 || c == 14, 0, "start_ignored");
      if (s_done) begin done_at = c; dones++; end
    end
    chk_int("ignored_done_cycle", done_at, 16);
    chk_int("ignored_done_count", dones, 1);
    chk_int("parity_before_reset", int'(s_par), 1);

    // Reset mid-scan at 7..8, restart at 10 (done at 26).
    done_at = -1; dones = 0;
    for (int c = 0; c < 30; c++) begin
      step_s(c == 7 || c == 8, c == 0 || c == 10, 0, "midreset");
      if (c == 7) chk_int("midreset_parity", int'(s_par), 0);
      if (s_done) begin done_at = c; dones++; end
    end
    chk_int("midreset_done_cycle", done_at, 26);
    chk_int("midreset_done_count", dones, 1);

    // Stall held through drain: timing unchanged.
    done_at = -1;
    for (int c = 0; c < 20; c++) begin
      step_s(0, c == 0, c >= 13, "drain_stall");
      if (s_done) done_at = c;
    end
    chk_int("drain_stall_done_cycle", done_at, 16);

    // Randomized stalls, starts and occasional resets.
    for (int c = 0; c < 600; c++) begin
      step_s($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, "random");
    end

    // Default-size grid, two back-to-back frames.
    m_h = BH; m_n = BH*BV;
    model_reset();
    dones = 0; issues = 0; prev_done = 0; last_h = -1; last_v = -1;
    for (int c = 0; c < 63200; c++) begin
      step_b(c == 0 || (prev_done && dones == 1), "big");
      prev_done = b_done;
      if (b_valid) begin
        issues++; last_h = int'(b_hor); last_v = int'(b_vert);
      end
      if (b_done) begin
        dones++;
        chk_int("big_last_hor", last_h, BH-1);
        chk_int("big_last_vert", last_v, BV-1);
      end
    end
    chk_int("big_done_count", dones, 2);
    chk_int("big_issue_count", issues, 2*BH*BV);
    chk_int("big_final_parity", int'(b_par), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/principal_scan_sequencer.md
Name: principal_scan_sequencer

Overview:
- Upstream address-generation stage for the lattice update.
- Walks the grid in principal order (left-to-right, then top-to-bottom) once per start request.
- Presents each (hor, vert) coordinate to the principal-to-all address mapper, which fans it out into the nine direction BRAM addresses.
- Tracks the fixed BRAM read latency, so downstream collision logic receives coordinates aligned with the returned data, plus a frame-done pulse.

Parameters:
- HPIXELS, 205, grid width in cells.
- VPIXELS, 154, grid height in cells.
- RW_LATENCY, 3, BRAM read latency in cycles from address issue to data valid.
- Derived, not overridable: HOR_SIZE = $clog2(HPIXELS); VERT_SIZE = $clog2(VPIXELS).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  one-cycle request to scan one full frame.
- stall_in  input  1  hold scan position; no coordinate is issued this cycle.
- hor_out  output  HOR_SIZE  issued column, to the address mapper.
- vert_out  output  VERT_SIZE  issued row, to the address mapper.
- valid_out  output  1  hor_out/vert_out are a real issue this cycle.
- rd_hor_out  output  HOR_SIZE  hor_out delayed RW_LATENCY cycles.
- rd_vert_out  output  VERT_SIZE  vert_out delayed RW_LATENCY cycles.
- rd_valid_out  output  1  valid_out delayed RW_LATENCY cycles; BRAM data for rd_* is present.
- busy_out  output  1  high from the cycle after an accepted start until the done pulse inclusive.
- done_out  output  1  one-cycle pulse when the frame's last read data has been delivered.
- frame_parity_out  output  1  toggles on each done pulse; selects the ping-pong buffer.

Behaviour:
- Reset: clock and reset are the single clk_in and the asynchronous active-low rst_n_in. Asserting rst_n_in low immediately forces:
  - all outputs to 0, including frame_parity_out;
  - the FSM to IDLE;
  - the delay pipeline to all-invalid.
  - Reset mid-scan abandons the frame; no done pulse is produced.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start_in = 1 -> SCAN; counters load (0,0).
  - start_in in any other state is ignored.
- SCAN:
  - Each cycle with stall_in = 0: valid_out = 1 and the current (hor, vert) is driven.
  - Advance: hor+1; at hor = HPIXELS-1, wrap hor to 0 and vert+1.
  - Issuing (HPIXELS-1, VPIXELS-1) -> DRAIN.
  - stall_in = 1: valid_out = 0, counters hold, hor_out/vert_out hold their last value.
- Issue latency: first issue in the cycle after start_in is sampled, if stall_in is low then.
- Delay pipeline:
  - RW_LATENCY-deep shift register of {valid, hor, vert}.
  - Shifts every cycle, independent of stall, because BRAM latency is fixed.
  - A stall produces an rd_valid_out bubble exactly RW_LATENCY cycles later.
- DRAIN:
  - valid_out = 0; stall_in is ignored.
  - Remains until the last issued coordinate appears on rd_*, i.e. its rd_valid_out cycle.
  - Then -> DONE.
- DONE: one cycle; done_out = 1, frame_parity_out toggles, -> IDLE. busy_out drops the following cycle.
- Unstalled frame timing: start sampled at cycle 0 gives:
  - issues at cycles 1..N, where N = HPIXELS*VPIXELS;
  - rd_valid_out at cycles 1+RW_LATENCY..N+RW_LATENCY;
  - done_out at cycle N+RW_LATENCY+1.
- Start in the DONE cycle is ignored; start in the first IDLE cycle after DONE is accepted, giving back-to-back frames.
- Width rules: counters are exactly HOR_SIZE/VERT_SIZE bits. Comparison against HPIXELS-1/VPIXELS-1 is done at full width, with no reliance on power-of-two overflow.

Test Plan:
- HPIXELS=4, VPIXELS=3, RW_LATENCY=3; reset, then start at cycle 0 -> valid_out at cycles 1..12 with coordinates (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2); rd_valid_out at cycles 4..15 with the same sequence; done_out only at cycle 16; frame_parity_out 0->1.
- Same config, stall_in high at cycles 3 and 4 -> coordinate (2,0) is issued at cycle 5; rd_valid_out low at cycles 6 and 7; done_out at cycle 18.
- start_in pulsed at cycles 5 and 14 during a scan -> no effect on sequence or timing; a single done_out.
- rst_n_in driven low at cycle 7 mid-scan, released at cycle 9 -> all outputs 0 from cycle 7; no done_out; a subsequent start restarts at (0,0) with frame_parity_out = 0.
- Default params 205x154, two back-to-back starts (second start in the cycle after done) -> two frames of 31570 issues each; last issue of each frame is (204,153); frame_parity_out ends at 0; done_out pulses exactly twice.
- stall_in held high throughout DRAIN -> ignored; done_out timing is identical to the unstalled run.
